arm_dp_encoder: RTL and testbench

Encodes a field-level request (operand kind, opcode, registers, shift, 32-bit constant) into a 32-bit ARM data-processing or MUL instruction word. It produces the bit layout that the core's instruction decoder consumes. It sits between the test-program sequencer (or a future assembler front-end) and instruction memory or the decoder input. A multi-cycle search finds the rotate/imm8 pair for 32-bit constants.

---
 rtl/arm_dp_encoder_pkg.sv | 69 ++++++
 rtl/arm_dp_encoder_if.sv | 34 +++
 rtl/arm_dp_encoder_imm_rot_check.sv | 21 ++
 rtl/arm_dp_encoder.sv | 163 ++++++++++++++++
 tb/tb_arm_dp_encoder.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_dp_encoder_pkg.sv
// Shared encodings for the ARM data-processing / MUL instruction encoder.
// DP opcode and shift constants are also used by the instruction decoder.
package arm_enc_pkg;

  typedef enum logic [1:0] {
    OP_IMM32        = 2'd0,
    OP_REG_IMMSHIFT = 2'd1,
    OP_REG_REGSHIFT = 2'd2,
    OP_MUL          = 2'd3
  } op_kind_e;

  localparam logic [3:0] DP_AND = 4'h0;
  localparam logic [3:0] DP_EOR = 4'h1;
  localparam logic [3:0] DP_SUB = 4'h2;
  localparam logic [3:0] DP_RSB = 4'h3;
  localparam logic [3:0] DP_ADD = 4'h4;
  localparam logic [3:0] DP_ADC = 4'h5;
  localparam logic [3:0] DP_SBC = 4'h6;
  localparam logic [3:0] DP_RSC = 4'h7;
  localparam logic [3:0] DP_TST = 4'h8;
  localparam logic [3:0] DP_TEQ = 4'h9;
  localparam logic [3:0] DP_CMP = 4'hA;
  localparam logic [3:0] DP_CMN = 4'hB;
  localparam logic [3:0] DP_ORR = 4'hC;
  localparam logic [3:0] DP_MOV = 4'hD;
  localparam logic [3:0] DP_BIC = 4'hE;
  localparam logic [3:0] DP_MVN = 4'hF;

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  localparam logic [3:0] COND_AL    = 4'hE;
  localparam logic [3:0] MUL_NIBBLE = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_OUT    = 2'd2
  } enc_state_e;

  // Full field-level request as presented on the bus.
  typedef struct packed {
    logic [1:0]  op_kind;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        s;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  rs;
    logic [1:0]  shift_type;
    logic [4:0]  shift_amt;
    logic [31:0] imm32;
  } enc_req_t;

  // Fields still needed after accept: only the immediate search outlives
  // the accept edge, the other forms are fully encoded on it.
  typedef struct packed {
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        s;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [31:0] imm32;
  } imm_req_t;

endpackage

// File: rtl/arm_dp_encoder_if.sv
// Request / instruction handshake bundle for the encoder.
interface arm_dp_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  op_kind;
  logic [3:0]  cond;
  logic [3:0]  opcode;
  logic        s;
  logic [3:0]  rn;
  logic [3:0]  rd;
  logic [3:0]  rm;
  logic [3:0]  rs;
  logic [1:0]  shift_type;
  logic [4:0]  shift_amt;
  logic [31:0] imm32;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] instruction;
  logic        err;

  // Request producer / instruction consumer side.
  modport master (
    output req_valid, op_kind, cond, opcode, s, rn, rd, rm, rs,
           shift_type, shift_amt, imm32, ins_ready,
    input  req_ready, ins_valid, instruction, err
  );

  // Encoder side.
  modport slave (
    input  req_valid, op_kind, cond, opcode, s, rn, rd, rm, rs,
           shift_type, shift_amt, imm32, ins_ready,
    output req_ready, ins_valid, instruction, err
  );
endinterface

// File: rtl/arm_dp_encoder_imm_rot_check.sv
// Checks whether imm32 is an 8-bit value rotated right by 2*rot.
// Rotating imm32 left by the same amount must leave only the low byte set.
module imm_rot_check (
  input  logic [31:0] imm32,
  input  logic [3:0]  rot,
  output logic        fit,
  output logic [7:0]  imm8
);
  logic [5:0]  amt;
  logic [63:0] dbl;
  logic [31:0] rolled;

  // ROL by 2*rot via a doubled word; rot = 0 shifts by 32, keeping imm32.
  always_comb begin
    amt    = {1'b0, rot, 1'b0};
    dbl    = {imm32, imm32} >> (6'd32 - amt);
    rolled = dbl[31:0];
    fit    = (rolled[31:8] == 24'd0);
    imm8   = rolled[7:0];
  end
endmodule

// File: rtl/arm_dp_encoder.sv
// Field-level request -> 32-bit ARM DP / MUL instruction word.
// Register and MUL forms are encoded on the accept edge; IMM32 walks
// rot = 0..15 one per cycle looking for the smallest encodable rotation.
module arm_dp_encoder
  import arm_enc_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  arm_dp_encoder_if.slave bus
);

  enc_state_e  state_q, state_d;
  logic [3:0]  rot_q, rot_d;
  enc_req_t    req_in;
  imm_req_t    imm_q;
  logic        ld_req;
  logic        ld_word;
  logic [31:0] word_d, word_q;
  logic        err_d, err_q;
  logic        fit;
  logic [7:0]  imm8;

  // DP layout with the compare-class and move-class forced fields applied.
  function automatic logic [31:0] dp_word(
    input logic [3:0]  cond,
    input logic [3:0]  opcode,
    input logic        s,
    input logic [3:0]  rn,
    input logic [3:0]  rd,
    input logic        ibit,
    input logic [11:0] op2
  );
    logic       s_f;
    logic [3:0] rn_f, rd_f;
    s_f  = s;
    rn_f = rn;
    rd_f = rd;
    if (opcode[3:2] == 2'b10) begin
      s_f  = 1'b1;
      rd_f = 4'd0;
    end
    if (opcode == DP_MOV || opcode == DP_MVN) rn_f = 4'd0;
    return {cond, 2'b00, ibit, opcode, s_f, rn_f, rd_f, op2};
  endfunction

  // Words that need no search, built straight from the bus fields.
  function automatic logic [31:0] direct_word(input enc_req_t r);
    logic [31:0] w;
    w = '0;
    case (r.op_kind)
      OP_REG_IMMSHIFT: w = dp_word(r.cond, r.opcode, r.s, r.rn, r.rd, 1'b0,
                                   {r.shift_amt, r.shift_type, 1'b0, r.rm});
      OP_REG_REGSHIFT: w = dp_word(r.cond, r.opcode, r.s, r.rn, r.rd, 1'b0,
                                   {r.rs, 1'b0, r.shift_type, 1'b1, r.rm});
      OP_MUL:          w = {r.cond, 7'd0, r.s, r.rd, 4'd0, r.rs, MUL_NIBBLE, r.rm};
      default:         w = '0;
    endcase
    return w;
  endfunction

  assign req_in = '{
    op_kind:    bus.op_kind,
    cond:       bus.cond,
    opcode:     bus.opcode,
    s:          bus.s,
    rn:         bus.rn,
    rd:         bus.rd,
    rm:         bus.rm,
    rs:         bus.rs,
    shift_type: bus.shift_type,
    shift_amt:  bus.shift_amt,
    imm32:      bus.imm32
  };

  imm_rot_check u_rot_check (
    .imm32 (imm_q.imm32),
    .rot   (rot_q),
    .fit   (fit),
    .imm8  (imm8)
  );

  // State and rotate counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rot_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      rot_q   <= rot_d;
    end
  end

  // Next state, request capture and word load decisions.
  always_comb begin
    state_d = state_q;
    rot_d   = rot_q;
    ld_req  = 1'b0;
    ld_word = 1'b0;
    word_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          ld_req = 1'b1;
          if (bus.op_kind == OP_IMM32) begin
            state_d = ST_SEARCH;
            rot_d   = 4'd0;
          end else begin
            state_d = ST_OUT;
            ld_word = 1'b1;
            word_d  = direct_word(req_in);
          end
        end
      end
      ST_SEARCH: begin
        if (fit) begin
          state_d = ST_OUT;
          ld_word = 1'b1;
          word_d  = dp_word(imm_q.cond, imm_q.opcode, imm_q.s, imm_q.rn,
                            imm_q.rd, 1'b1, {rot_q, imm8});
        end else if (rot_q == 4'd15) begin
          state_d = ST_OUT;
          ld_word = 1'b1;
          err_d   = 1'b1;
        end else begin
          rot_d = rot_q + 4'd1;
        end
      end
      ST_OUT: begin
        // Handshake clears the word so nothing stale lingers while idle.
        if (bus.ins_ready) begin
          state_d = ST_IDLE;
          ld_word = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the fields the immediate search still needs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      imm_q <= '0;
    else if (ld_req) imm_q <= '{cond: req_in.cond, opcode: req_in.opcode, s: req_in.s,
                                rn: req_in.rn, rd: req_in.rd, imm32: req_in.imm32};
  end

  // Output word and error flag, held steady through backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      err_q  <= 1'b0;
    end else if (ld_word) begin
      word_q <= word_d;
      err_q  <= err_d;
    end
  end

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.ins_valid   = (state_q == ST_OUT);
  assign bus.instruction = word_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_arm_dp_encoder.sv
// Randomized scoreboard bench for arm_dp_encoder.
module tb_arm_dp_encoder;
  import arm_enc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   rdy_mode = 0;   // 0: ready, 1: random, 2: held low

  typedef struct {
    logic [31:0] word;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];

  arm_dp_encoder_if bus ();

  arm_dp_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: what an assembler would emit for these fields.
  function automatic exp_t model(input enc_req_t r, input int acc);
    exp_t        e;
    logic [31:0] base, v;
    logic        s_e;
    logic [3:0]  rn_e, rd_e;
    bit          found;
    e.acc = acc;
    e.err = 1'b0;
    e.lat = 1;
    if (r.op_kind == 2'd3) begin
      e.word = (32'(r.cond) << 28) | (32'(r.s) << 20) | (32'(r.rd) << 16)
             | (32'(r.rs) << 8) | (32'd9 << 4) | 32'(r.rm);
      return e;
    end
    s_e  = (r.opcode >= 4'd8 && r.opcode <= 4'd11) ? 1'b1 : r.s;
    rd_e = (r.opcode >= 4'd8 && r.opcode <= 4'd11) ? 4'd0 : r.rd;
    rn_e = (r.opcode == 4'd13 || r.opcode == 4'd15) ? 4'd0 : r.rn;
    base = (32'(r.cond) << 28) | (32'(r.opcode) << 21) | (32'(s_e) << 20)
         | (32'(rn_e) << 16) | (32'(rd_e) << 12);
    if (r.op_kind == 2'd1) begin
      e.word = base | (32'(r.shift_amt) << 7) | (32'(r.shift_type) << 5) | 32'(r.rm);
    end else if (r.op_kind == 2'd2) begin
      e.word = base | (32'(r.rs) << 8) | (32'(r.shift_type) << 5) | 32'h10 | 32'(r.rm);
    end else begin
      found = 0;
      for (int k = 0; k < 16 && !found; k++) begin
        v = ror32(r.imm32, (32 - 2 * k) % 32);   // left rotate by 2k
        if (v < 256 && ror32(v, 2 * k) == r.imm32) begin
          found  = 1;
          e.word = base | 32'h0200_0000 | (32'(k) << 8) | v;
          e.lat  = k + 2;
        end
      end
      if (!found) begin
        e.word = 32'd0;
        e.err  = 1'b1;
        e.lat  = 17;
      end
    end
    return e;
  endfunction

  function automatic enc_req_t mk(input logic [1:0] kind, input logic [3:0] cond,
                                  input logic [3:0] opc, input logic s,
                                  input logic [3:0] rn, input logic [3:0] rd,
                                  input logic [3:0] rm, input logic [3:0] rs,
                                  input logic [1:0] st, input logic [4:0] sa,
                                  input logic [31:0] imm);
    enc_req_t r;
    r = '{op_kind: kind, cond: cond, opcode: opc, s: s, rn: rn, rd: rd, rm: rm,
          rs: rs, shift_type: st, shift_amt: sa, imm32: imm};
    return r;
  endfunction

  function automatic enc_req_t rand_req();
    enc_req_t    r;
    logic [31:0] imm;
    case ($urandom_range(0, 3))
      0:       imm = $urandom;
      1:       imm = ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
      2:       imm = 32'($urandom_range(0, 600));
      default: imm = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
    endcase
    r = mk(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 31)), imm);
    return r;
  endfunction

  // Present a request and hold it until accepted; expectation queued at accept.
  task automatic send(input enc_req_t r);
    int n;
    n = 0;
    @(negedge clk);
    bus.op_kind    = r.op_kind;
    bus.cond       = r.cond;
    bus.opcode     = r.opcode;
    bus.s          = r.s;
    bus.rn         = r.rn;
    bus.rd         = r.rd;
    bus.rm         = r.rm;
    bus.rs         = r.rs;
    bus.shift_type = r.shift_type;
    bus.shift_amt  = r.shift_amt;
    bus.imm32      = r.imm32;
    bus.req_valid  = 1'b1;
    while (!bus.req_ready) begin
      n++;
      if (n > 300) begin
        chk("accept_timeout", 32'd1, 32'd0);
        bus.req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    exp_q.push_back(model(r, cyc + 1));
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // Consumer ready pattern, changed just after each rising edge.
  initial begin
    bus.ins_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.ins_ready = 1'b1;
        1:       bus.ins_ready = ($urandom_range(0, 3) != 0);
        default: bus.ins_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every valid cycle must show the head expectation; pop on handshake.
  initial begin
    bit vprev;
    int rise;
    exp_t e;
    vprev = 0;
    rise  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vprev = 0;
      end else begin
        if (bus.ins_valid) begin
          if (!vprev) rise = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected_ins_valid", 32'd1, 32'd0);
          end else begin
            e = exp_q[0];
            chk("instruction", bus.instruction, e.word);
            chk("err", 32'(bus.err), 32'(e.err));
            chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
            if (bus.ins_ready) begin
              chk("latency", 32'(rise - e.acc + 1), 32'(e.lat));
              void'(exp_q.pop_front());
            end
          end
        end
        vprev = bus.ins_valid;
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.op_kind    = '0;
    bus.cond       = '0;
    bus.opcode     = '0;
    bus.s          = 1'b0;
    bus.rn         = '0;
    bus.rd         = '0;
    bus.rm         = '0;
    bus.rs         = '0;
    bus.shift_type = '0;
    bus.shift_amt  = '0;
    bus.imm32      = '0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_ins_valid", 32'(bus.ins_valid), 32'd0);
    chk("reset_instruction", bus.instruction, 32'd0);
    chk("reset_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;

    // Directed cases with hand-derived words as well as the model.
    send(mk(2'd0, COND_AL, DP_ADD, 1'b0, 4'd2, 4'd1, 4'd0, 4'd0, SH_LSL, 5'd0, 32'h0000_00FF));
    chk("add_imm_model", exp_q[$].word, 32'hE282_10FF);
    send(mk(2'd0, COND_AL, DP_MOV, 1'b0, 4'd5, 4'd0, 4'd0, 4'd0, SH_LSL, 5'd0, 32'hFF00_0000));
    chk("mov_imm_model", exp_q[$].word, 32'hE3A0_04FF);
    send(mk(2'd0, COND_AL, DP_ADD, 1'b0, 4'd1, 4'd2, 4'd0, 4'd0, SH_LSL, 5'd0, 32'h0000_0101));
    send(mk(2'd0, COND_AL, DP_ORR, 1'b1, 4'd3, 4'd4, 4'd0, 4'd0, SH_LSL, 5'd0, 32'h0000_0000));
    send(mk(2'd1, COND_AL, DP_SUB, 1'b1, 4'd4, 4'd3, 4'd5, 4'd0, SH_LSL, 5'd2, 32'h0));
    chk("subs_model", exp_q[$].word, 32'hE054_3105);
    send(mk(2'd1, COND_AL, DP_CMP, 1'b0, 4'd4, 4'd9, 4'd5, 4'd0, SH_LSL, 5'd0, 32'h0));
    send(mk(2'd3, COND_AL, DP_AND, 1'b0, 4'd0, 4'd7, 4'd8, 4'd9, SH_LSL, 5'd0, 32'h0));
    send(mk(2'd2, 4'h1, DP_EOR, 1'b0, 4'd6, 4'd7, 4'd8, 4'd9, SH_ROR, 5'd0, 32'h0));
    send(mk(2'd0, COND_AL, DP_MVN, 1'b0, 4'd9, 4'd1, 4'd0, 4'd0, SH_LSL, 5'd0, 32'h0000_03FC));
    drain();

    // Backpressure: word and err must hold while ins_ready stays low.
    rdy_mode = 2;
    send(mk(2'd2, COND_AL, DP_BIC, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4, SH_ASR, 5'd0, 32'h0));
    repeat (4) @(negedge clk);
    rdy_mode = 0;
    drain();
    rdy_mode = 2;
    send(mk(2'd0, COND_AL, DP_ADD, 1'b0, 4'd1, 4'd2, 4'd0, 4'd0, SH_LSL, 5'd0, 32'h8000_0001));
    repeat (22) @(negedge clk);
    rdy_mode = 0;
    drain();

    // Random traffic under random backpressure.
    rdy_mode = 1;
    repeat (150) send(rand_req());
    drain();
    rdy_mode = 0;
    repeat (2) @(negedge clk);

    // Reset during SEARCH discards the pending word.
    send(mk(2'd0, COND_AL, DP_ADD, 1'b0, 4'd1, 4'd2, 4'd0, 4'd0, SH_LSL, 5'd0, 32'h0000_0101));
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_search_ins_valid", 32'(bus.ins_valid), 32'd0);
    chk("rst_search_req_ready", 32'(bus.req_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_stale_word", 32'(bus.ins_valid), 32'd0);
    end

    // Reset while the word is waiting in OUT drops ins_valid at once.
    rdy_mode = 2;
    send(mk(2'd3, COND_AL, DP_AND, 1'b1, 4'd0, 4'd3, 4'd4, 4'd5, SH_LSL, 5'd0, 32'h0));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_ins_valid", 32'(bus.ins_valid), 32'd0);
    chk("rst_out_instruction", bus.instruction, 32'd0);
    exp_q.delete();
    rdy_mode = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Normal operation resumes after reset.
    send(mk(2'd1, COND_AL, DP_MOV, 1'b1, 4'd7, 4'd2, 4'd3, 4'd0, SH_LSR, 5'd31, 32'h0));
    send(mk(2'd0, COND_AL, DP_TST, 1'b0, 4'd2, 4'd6, 4'd0, 4'd0, SH_LSL, 5'd0, 32'h0003_FC00));
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    chk("global_timeout", 32'd1, 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
